// File: rtl/addsub_arb_pkg.sv
// addsub_arb_pkg: shared constants and types for the add/sub round-robin
// arbiter slice.
//   DATA_W    : ALU operand/result width
//   NREQ_DEF  : default requester count
//   CNT_W_DEF : default statistics counter width (ADDSUB_ARB_STATS_EN only)
//   mode_e    : ALU operation select (MODE_ADD = A+B, MODE_SUB = A-B)
package addsub_arb_pkg;

  localparam int DATA_W    = 8;
  localparam int NREQ_DEF  = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/adder_subtractor.sv
// adder_subtractor: 8-bit two's-complement adder/subtractor, combinational.
// Ports:
//   a, b   : operands
//   mode   : 0 = a+b, 1 = a-b
//   result : modulo-2^8 result
//   ovfl   : signed overflow (carry/borrow not reported)
module adder_subtractor
  import addsub_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mode,
  output logic [DATA_W-1:0] result,
  output logic              ovfl
);

  logic [DATA_W-1:0] b_eff;

  // Subtraction is a + ~b + 1; the carry-in is the mode bit itself.
  assign b_eff  = (mode == MODE_SUB) ? ~b : b;
  assign result = a + b_eff + DATA_W'(mode);
  // Overflow when both effective operands share a sign the result lacks.
  assign ovfl   = (a[DATA_W-1] == b_eff[DATA_W-1]) &&
                  (result[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin one-hot grant.
// Ports:
//   req : request vector
//   ptr : highest-priority index; search runs ptr, ptr+1, ... wrapping at NREQ
//   en  : grant enable; gnt is all-zero when low
//   gnt : one-hot grant on the first asserted req at or after ptr
module rr_grant #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NREQ);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter: shares one adder_subtractor between NREQ requesters.
// Round-robin valid/ready issue side, single registered response slot with
// backpressure on the return side.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot grant)
//   req_a, req_b        : packed operands, requester i at [8i+7:8i]
//   req_mode            : per-requester op, 0 = A+B, 1 = A-B
//   rsp_valid/rsp_ready : response slot handshake
//   rsp_id, rsp_result, rsp_ovfl : held response
//   busy                : response held or any request pending
// Optional (macro ADDSUB_ARB_STATS_EN):
//   stat_clr            : synchronous clear of the counters (wins over increment)
//   stat_ops, stat_ovfl : saturating accept / overflow-accept counters
module addsub_rr_arbiter
  import addsub_arb_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
`ifdef ADDSUB_ARB_STATS_EN
  parameter  int CNT_W = CNT_W_DEF,
`endif
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_mode,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_result,
  output logic                   rsp_ovfl,
  output logic                   busy
`ifdef ADDSUB_ARB_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [CNT_W-1:0]       stat_ops,
  output logic [CNT_W-1:0]       stat_ovfl
`endif
);

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   sel_id;
  logic              free;
  logic              accept;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_mode;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovfl;

  assign free = !rsp_valid || rsp_ready;
  assign busy = rsp_valid || (|req_valid);

  // rst_n gates the enable so req_ready reads 0 while reset is held.
  rr_grant #(.NREQ(NREQ)) u_grant (
    .req (req_valid),
    .ptr (ptr),
    .en  (free && rst_n),
    .gnt (req_ready)
  );

  assign accept = |req_ready;

  // One-hot operand select; only the granted requester drives the ALU.
  always_comb begin
    sel_id   = '0;
    alu_a    = '0;
    alu_b    = '0;
    alu_mode = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_id   = ID_W'(i);
        alu_a    = req_a[i*DATA_W +: DATA_W];
        alu_b    = req_b[i*DATA_W +: DATA_W];
        alu_mode = req_mode[i];
      end
    end
  end

  adder_subtractor u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .mode   (alu_mode),
    .result (alu_result),
    .ovfl   (alu_ovfl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_ovfl   <= 1'b0;
      ptr        <= '0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= sel_id;
      rsp_result <= alu_result;
      rsp_ovfl   <= alu_ovfl;
      ptr        <= (sel_id == ID_W'(NREQ - 1)) ? '0 : sel_id + 1'b1;
    end else if (rsp_ready) begin
      // Pop only: payload keeps its last value.
      rsp_valid  <= 1'b0;
    end
  end

`ifdef ADDSUB_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_ovfl <= '0;
    end else if (stat_clr) begin
      stat_ops  <= '0;
      stat_ovfl <= '0;
    end else if (accept) begin
      if (stat_ops != '1) stat_ops <= stat_ops + 1'b1;
      if (alu_ovfl && (stat_ovfl != '1)) stat_ovfl <= stat_ovfl + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// tb_addsub_rr_arbiter: scoreboard bench for addsub_rr_arbiter (NREQ = 4).
// Optional stats checks are compiled when ADDSUB_ARB_STATS_EN is defined.
module tb_addsub_rr_arbiter;
  import addsub_arb_pkg::*;

  localparam int N  = 4;
  localparam int CW = 16;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
  } op_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] res;
    logic       ovfl;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic [N-1:0] req_mode;
  logic [N-1:0] req_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [7:0]   rsp_result;
  logic         rsp_ovfl;
  logic         busy;
`ifdef ADDSUB_ARB_STATS_EN
  logic          stat_clr;
  logic [CW-1:0] stat_ops;
  logic [CW-1:0] stat_ovfl;
  logic [CW-1:0] m_ops;
  logic [CW-1:0] m_ovfl;
`endif

  always #5 clk = ~clk;

  addsub_rr_arbiter #(.NREQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_mode   (req_mode),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ovfl   (rsp_ovfl),
    .busy       (busy)
`ifdef ADDSUB_ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_ops   (stat_ops),
    .stat_ovfl  (stat_ovfl)
`endif
  );

  // Requester state and bench model
  op_t          cur [N];
  int unsigned  left [N];
  logic [N-1:0] want;
  logic [N-1:0] acc;
  logic         rdy;
  logic         rnd_rdy;
  logic         ovfl_ops;
  logic         mvalid;
  int unsigned  mptr;
  rsp_t         sb [$];
  int unsigned  glog [$];
  int unsigned  rr_exp [5] = '{0, 1, 2, 3, 0};
  int           checks = 0;
  int           errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic rsp_t model(input int unsigned id, input op_t o);
    rsp_t r;
    r.id = 2'(id);
    if (o.mode) begin
      r.res  = o.a - o.b;
      r.ovfl = (o.a[7] != o.b[7]) && (r.res[7] != o.a[7]);
    end else begin
      r.res  = o.a + o.b;
      r.ovfl = (o.a[7] == o.b[7]) && (r.res[7] != o.a[7]);
    end
    return r;
  endfunction

  function automatic op_t new_op();
    op_t o;
    if (ovfl_ops) begin
      o.a = 8'h6D; o.b = 8'h45; o.mode = 1'b0;
    end else begin
      o.a = 8'($urandom); o.b = 8'($urandom); o.mode = 1'($urandom);
    end
    return o;
  endfunction

  task automatic apply();
    req_valid = want;
    for (int i = 0; i < N; i++) begin
      req_a[i*8 +: 8] = cur[i].a;
      req_b[i*8 +: 8] = cur[i].b;
      req_mode[i]     = cur[i].mode;
    end
    rsp_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy;
  endtask

  // Sampled on the falling edge: compare, pop, then push for the coming edge.
  task automatic monitor();
    logic [N-1:0] eg;
    logic         fr;
    int unsigned  j;
    rsp_t         e;
    acc = '0;
    if (!rst_n) return;
    check_eq("rsp_valid", 32'(rsp_valid), 32'(mvalid));
    check_eq("busy", 32'(busy), 32'(mvalid | (|want)));
`ifdef ADDSUB_ARB_STATS_EN
    check_eq("stat_ops", 32'(stat_ops), 32'(m_ops));
    check_eq("stat_ovfl", 32'(stat_ovfl), 32'(m_ovfl));
`endif
    fr = !mvalid || rsp_ready;
    eg = '0;
    if (fr) begin
      for (int k = 0; k < N; k++) begin
        j = (mptr + 32'(k)) % N;
        if (want[j] && eg == '0) eg[j] = 1'b1;
      end
    end
    check_eq("grant", 32'(req_ready), 32'(eg));
    if (mvalid && rsp_ready) begin
      check_eq("sb_depth", 32'(sb.size()), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("rsp", 32'({rsp_id, rsp_result, rsp_ovfl}), 32'(e));
      end
    end
`ifdef ADDSUB_ARB_STATS_EN
    if (stat_clr) begin
      m_ops = '0; m_ovfl = '0;
    end
`endif
    for (int i = 0; i < N; i++) begin
      if (eg[i]) begin
        e = model(i, cur[i]);
        sb.push_back(e);
        glog.push_back(i);
        mptr = (i + 1) % N;
`ifdef ADDSUB_ARB_STATS_EN
        if (!stat_clr) begin
          if (m_ops != '1) m_ops = m_ops + 1'b1;
          if (e.ovfl && m_ovfl != '1) m_ovfl = m_ovfl + 1'b1;
        end
`endif
      end
    end
    if (eg != '0) mvalid = 1'b1;
    else if (rsp_ready) mvalid = 1'b0;
    acc = eg;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (left[i] > 0) begin
          left[i]--;
          cur[i] = new_op();
        end else begin
          want[i] = 1'b0;
        end
      end
    end
    apply();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; want = '0; rdy = 1'b0; rnd_rdy = 1'b0; ovfl_ops = 1'b0;
    mvalid = 1'b0; mptr = 0; acc = '0;
`ifdef ADDSUB_ARB_STATS_EN
    stat_clr = 1'b0; m_ops = '0; m_ovfl = '0;
`endif
    for (int i = 0; i < N; i++) begin
      cur[i] = new_op();
      left[i] = 0;
    end

    // Reset held with random requests
    for (int n = 0; n < 4; n++) begin
      want = N'($urandom);
      apply();
      #3;
      check_eq("rst_ready", 32'(req_ready), 0);
      check_eq("rst_valid", 32'(rsp_valid), 0);
      @(posedge clk);
      #1;
    end
    want = '0; rdy = 1'b1; apply();
    rst_n = 1'b1;
    step(); step();
    check_eq("idle_busy", 32'(busy), 0);
    check_eq("idle_ready", 32'(req_ready), 0);

    // Single add with overflow, then subtract without
    cur[0] = '{a: 8'h6D, b: 8'h45, mode: 1'b0}; want = 4'b0001; apply();
    step();
    check_eq("add_rsp", 32'({rsp_valid, rsp_id, rsp_result, rsp_ovfl}), 32'({1'b1, 2'd0, 8'hB2, 1'b1}));
    cur[0] = '{a: 8'h80, b: 8'h9C, mode: 1'b1}; want = 4'b0001; apply();
    step();
    check_eq("sub_rsp", 32'({rsp_valid, rsp_id, rsp_result, rsp_ovfl}), 32'({1'b1, 2'd0, 8'hE4, 1'b0}));

    // Backpressure: req2 result held 5 cycles while req0 waits
    cur[2] = '{a: 8'hF0, b: 8'h01, mode: 1'b0}; want = 4'b0100; apply();
    step();
    rdy = 1'b0; cur[0] = '{a: 8'h11, b: 8'h22, mode: 1'b0}; want = 4'b0001; apply();
    for (int n = 0; n < 5; n++) begin
      step();
      check_eq("hold_rsp", 32'({rsp_valid, rsp_id, rsp_result, rsp_ovfl}), 32'({1'b1, 2'd2, 8'hF1, 1'b0}));
      check_eq("hold_ready", 32'(req_ready), 0);
    end
    rdy = 1'b1; apply();
    #1;
    check_eq("release_grant", 32'(req_ready), 32'(4'b0001));
    step();
    check_eq("release_rsp", 32'({rsp_valid, rsp_id, rsp_result, rsp_ovfl}), 32'({1'b1, 2'd0, 8'h33, 1'b0}));
    rdy = 1'b0; apply();
    step();

    // Reset with a held response; pointer is at 1 beforehand
    for (int i = 0; i < N; i++) begin
      cur[i] = new_op();
      left[i] = 1;
    end
    cur[1] = '{a: 8'h01, b: 8'h81, mode: 1'b1};
    want = '1; apply();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", 32'(rsp_valid), 0);
    check_eq("rst_async_ready", 32'(req_ready), 0);
    sb.delete(); glog.delete(); mvalid = 1'b0; mptr = 0;
`ifdef ADDSUB_ARB_STATS_EN
    m_ops = '0; m_ovfl = '0;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1; rdy = 1'b1; apply();
    #1;
    check_eq("post_rst_grant", 32'(req_ready), 32'(4'b0001));

    // Round-robin with all requesters valid
    step(); step();
    check_eq("rr_req1", 32'({rsp_valid, rsp_id, rsp_result, rsp_ovfl}), 32'({1'b1, 2'd1, 8'h80, 1'b1}));
    step(); step(); step();
    for (int k = 0; k < 5; k++)
      check_eq("rr_order", (k < glog.size()) ? glog[k] : 99, rr_exp[k]);

    // Random traffic with random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < N; i++) left[i] = 40;
    want = '1; apply();
    for (int n = 0; n < 3000 && want != '0; n++) step();
    rnd_rdy = 1'b0; rdy = 1'b1; apply();
    for (int n = 0; n < 20 && (want != '0 || mvalid); n++) step();
    check_eq("drain", 32'({want, mvalid}), 0);
    check_eq("sb_empty", 32'(sb.size()), 0);

`ifdef ADDSUB_ARB_STATS_EN
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    for (int n = 0; n < 10; n++) begin
      cur[0] = (n < 3) ? op_t'('{a: 8'h6D, b: 8'h45, mode: 1'b0})
                       : op_t'('{a: 8'h01, b: 8'h02, mode: 1'b0});
      want = 4'b0001; apply();
      step();
    end
    step();
    check_eq("stat10_ops", 32'(stat_ops), 10);
    check_eq("stat10_ovfl", 32'(stat_ovfl), 3);
    cur[0] = '{a: 8'h6D, b: 8'h45, mode: 1'b0};
    want = 4'b0001; stat_clr = 1'b1; apply();
    step();
    stat_clr = 1'b0;
    check_eq("clr_ops", 32'(stat_ops), 0);
    check_eq("clr_ovfl", 32'(stat_ovfl), 0);
    ovfl_ops = 1'b1; cur[0] = new_op(); left[0] = 65540; want = 4'b0001; apply();
    for (int n = 0; n < 70000 && want != '0; n++) step();
    step(); step();
    check_eq("sat_ops", 32'(stat_ops), 32'hFFFF);
    check_eq("sat_ovfl", 32'(stat_ovfl), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
Shares one 8-bit two's-complement adder/subtractor (instance of adder_subtractor, ports a, b, mode, result, ovfl) between NREQ requesters. Uses a round-robin valid/ready arbiter on the request side and a single registered response slot with backpressure on the result side. It is the issue/return scheduler in front of the shared ALU datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, $clog2(NREQ), width of requester ID (derived, not overridden)
CNT_W, 16, width of statistics counters (optional feature only)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operation valid
req_a  in  NREQ*8  packed operand A, requester i at [8i+7:8i]
req_b  in  NREQ*8  packed operand B, same packing
req_mode  in  NREQ  0 = A+B, 1 = A-B
req_ready  out  NREQ  one-hot grant; request i accepted when req_valid[i] && req_ready[i]
rsp_valid  out  1  response slot holds a result
rsp_ready  in  1  consumer accepts response
rsp_id  out  ID_W  requester index of the held result
rsp_result  out  8  registered ALU result
rsp_ovfl  out  1  registered signed-overflow flag
busy  out  1  high while rsp_valid or any req_valid is high

Behaviour:
- Single clock domain; clk and rst_n only. Reset is asynchronous assert, synchronous deassert externally.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_ovfl=0, rr pointer=0 (requester 0 highest priority), req_ready=0.
- Slot free condition: free = !rsp_valid || rsp_ready.
- req_ready is combinational. When free, it is one-hot on the first asserted req_valid at or after the pointer, wrapping from NREQ-1 to 0. When !free or no req_valid, it is 0. req_ready never asserts for a requester with req_valid=0.
- On accept (some req_valid[i] && req_ready[i]):
  - Next edge loads rsp_result/rsp_ovfl from the ALU on req_a[i], req_b[i], req_mode[i]. rsp_id=i, rsp_valid=1.
  - Pointer = (i+1) mod NREQ.
  - Latency: accept cycle to rsp_valid is 1 cycle.
- Response hold: while rsp_valid && !rsp_ready, rsp_* are stable and no grant is issued.
- Simultaneous pop and push: rsp_ready=1 with a pending request gives full throughput of 1 op/cycle, and the slot is reloaded on the same edge.
- Pop only: rsp_valid clears. rsp_result/rsp_ovfl/rsp_id keep their last values.
- No accept: pointer is unchanged.
- Arithmetic: 8-bit modulo.
  - ovfl = signed overflow: add: a[7]==b[7] && res[7]!=a[7]; sub: a[7]!=b[7] && res[7]!=a[7].
  - Carry/borrow is not reported.
- Fairness: a continuously-valid requester is granted within NREQ accepts.
- Reset mid-operation: any held response is discarded and the pointer returns to 0. Requesters must re-issue.
- Requesters keep req_* stable while valid and not granted. This is protocol, not checked in RTL.

Optional Feature:
Macro ADDSUB_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_ops (CNT_W) and stat_ovfl (CNT_W), both reset to 0.
  - stat_ops increments on every accept.
  - stat_ovfl increments on every accept whose ALU ovfl=1.
  - Both saturate at all-ones.
  - Adds input stat_clr (1), a synchronous clear that takes priority over increment on the same edge.
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Package addsub_arb_pkg:
  - DATA_W=8
  - MODE_ADD=1'b0, MODE_SUB=1'b1
  - default NREQ and CNT_W constants
- Sub-module rr_grant(NREQ): pure combinational round-robin one-hot grant from req vector, pointer and enable. Reusable by later arbiters.
- The ALU is the existing adder_subtractor, instantiated once. No arithmetic is duplicated in this block.

Test Plan:
- Reset/idle: hold rst_n=0 with random req_valid -> rsp_valid=0, req_ready=0. After release with req_valid=0 -> busy=0, no grants.
- Single add with overflow: req0 a=0x6D b=0x45 mode=0, rsp_ready=1 -> next cycle rsp_valid=1, id=0, result=0xB2, ovfl=1. Also req0 a=0x80 b=0x9C mode=1 -> result=0xE4, ovfl=0.
- Round-robin: all 4 requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0 one per cycle. Each rsp_id matches its own operands, e.g. req1 a=0x01 b=0x81 mode=1 -> result=0x80, ovfl=1.
- Backpressure: rsp_ready=0 for 5 cycles with req2 a=0xF0 b=0x01 mode=0 held -> rsp_result=0xF1, ovfl=0 stable. req_ready=0 throughout. Raising rsp_ready grants the next pending request on that cycle.
- Reset mid-flight: assert rst_n=0 while rsp_valid=1 -> rsp_valid drops immediately (asynchronous). The first grant after release goes to the lowest valid index.
- Stats (ADDSUB_ARB_STATS_EN): 10 ops with 3 overflows -> stat_ops=10, stat_ovfl=3. Asserting stat_clr on the same edge as an accept -> both 0. Preloading near saturation -> counters hold at 0xFFFF.
